// File: rtl/ip_scc.sv
// rtl/ip_scc.sv - Konami SCC / SCC+ five-channel wavetable sound generator
//
// Ports:
//   clk, n_reset                    clock, asynchronous active-low reset
//   enable                          sound tick strobe; tone counters and mixer advance on it
//   bus_address, bus_write_data     CPU bus address and write data
//   bus_read, bus_write, bus_memory CPU strobes; only memory cycles are decoded
//   bus_read_ready, bus_read_data   read response, one clk after bus_read on a hit
//   scc_bank_en, sccp_bank_en       register window qualifiers from the external mapper
//   sccp_en                         1 = SCC+ layout and independent ch4 wave
//   sound_out                       mixed signed 11-bit sample
//
// Optional feature macro: SCC_WAVE_READ_EN (wave RAM readable; otherwise wave reads return FFh)

module ip_scc (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        enable,
    input  logic [15:0] bus_address,
    output logic        bus_read_ready,
    output logic [7:0]  bus_read_data,
    input  logic [7:0]  bus_write_data,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic        bus_memory,
    input  logic        scc_bank_en,
    input  logic        sccp_bank_en,
    input  logic        sccp_en,
    output logic [10:0] sound_out
);

    logic [7:0]  wave    [0:4][0:31];
    logic [11:0] period  [0:4];
    logic [11:0] cnt     [0:4];
    logic [4:0]  ptr     [0:4];
    logic [3:0]  volume  [0:4];
    logic [4:0]  ch_en;

    logic        hit;
    logic        is_wave;
    logic        is_reg;
    logic [2:0]  wave_ch;
    logic [4:0]  wave_idx;
    logic [3:0]  reg_sel;
    logic [2:0]  per_ch;
    logic [2:0]  vol_ch;
    logic [7:0]  rd_byte;

    // Address decode; the low byte is mirrored across the whole window.
    always_comb begin
        hit      = bus_memory && (sccp_en ? (sccp_bank_en && bus_address[15:11] == 5'b10111)
                                          : (scc_bank_en  && bus_address[15:11] == 5'b10011));
        wave_idx = bus_address[4:0];
        reg_sel  = bus_address[3:0];
        per_ch   = reg_sel[3:1];
        vol_ch   = 3'(reg_sel - 4'd10);
        if (sccp_en) begin
            is_wave = bus_address[7:0] < 8'hA0;
            is_reg  = bus_address[7:5] == 3'b101;
            wave_ch = bus_address[7:5];
        end else begin
            is_wave = !bus_address[7];
            is_reg  = bus_address[7:5] == 3'b100;
            wave_ch = {1'b0, bus_address[6:5]};
        end
`ifdef SCC_WAVE_READ_EN
        rd_byte = is_wave ? wave[wave_ch][wave_idx] : 8'hFF;
`else
        rd_byte = 8'hFF;
`endif
    end

    // Register file and tone counters share one block so a period write can
    // override the tick update of the same counter on the same edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < 5; c++) begin
                for (int i = 0; i < 32; i++) begin
                    wave[c][i] <= 8'h00;
                end
                period[c] <= 12'h000;
                cnt[c]    <= 12'h000;
                ptr[c]    <= 5'd0;
                volume[c] <= 4'h0;
            end
            ch_en <= 5'b00000;
        end else begin
            if (enable) begin
                for (int c = 0; c < 5; c++) begin
                    // Periods of 8 or less are too fast to be audible; the channel freezes.
                    if (period[c] > 12'd8) begin
                        if (cnt[c] == 12'd0) begin
                            cnt[c] <= period[c];
                            ptr[c] <= ptr[c] + 5'd1;
                        end else begin
                            cnt[c] <= cnt[c] - 12'd1;
                        end
                    end
                end
            end
            if (hit && bus_write) begin
                if (is_wave) begin
                    wave[wave_ch][wave_idx] <= bus_write_data;
                end else if (is_reg) begin
                    if (reg_sel <= 4'd9) begin
                        if (!reg_sel[0]) begin
                            period[per_ch][7:0] <= bus_write_data;
                            cnt[per_ch]         <= {period[per_ch][11:8], bus_write_data};
                        end else begin
                            period[per_ch][11:8] <= bus_write_data[3:0];
                            cnt[per_ch]          <= {bus_write_data[3:0], period[per_ch][7:0]};
                        end
                    end else if (reg_sel <= 4'd14) begin
                        volume[vol_ch] <= bus_write_data[3:0];
                    end else begin
                        ch_en <= bus_write_data[4:0];
                    end
                end
            end
        end
    end

    // Read path samples storage before this edge's write lands, so a
    // simultaneous read and write returns the old byte.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus_read_ready <= 1'b0;
            bus_read_data  <= 8'h00;
        end else begin
            bus_read_ready <= hit && bus_read;
            if (hit && bus_read) begin
                bus_read_data <= rd_byte;
            end
        end
    end

    logic [2:0]         src;
    logic [7:0]         samp;
    logic signed [12:0] prod;
    logic [10:0]        mix;

    // In SCC compatible mode ch4 has no RAM of its own and replays the ch3 table.
    always_comb begin
        mix  = 11'd0;
        src  = 3'd0;
        samp = 8'h00;
        prod = 13'sd0;
        for (int c = 0; c < 5; c++) begin
            src  = (c == 4 && !sccp_en) ? 3'd3 : 3'(c);
            samp = wave[src][ptr[c]];
            prod = ch_en[c] ? $signed(samp) * $signed({1'b0, volume[c]}) : 13'sd0;
            mix  = mix + {{2{prod[12]}}, prod[12:4]};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sound_out <= 11'd0;
        end else if (enable) begin
            sound_out <= mix;
        end
    end

endmodule

// File: tb/tb_ip_scc.sv
// tb/tb_ip_scc.sv - scoreboard testbench for ip_scc

module tb_ip_scc;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bus_address = 16'h0000;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;
    logic [7:0]  bus_write_data = 8'h00;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_memory = 1'b0;
    logic        scc_bank_en = 1'b0;
    logic        sccp_bank_en = 1'b0;
    logic        sccp_en = 1'b0;
    logic [10:0] sound_out;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          run_en = 1'b0;
    int          ediv = 0;

    ip_scc dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .enable         (enable),
        .bus_address    (bus_address),
        .bus_read_ready (bus_read_ready),
        .bus_read_data  (bus_read_data),
        .bus_write_data (bus_write_data),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_memory     (bus_memory),
        .scc_bank_en    (scc_bank_en),
        .sccp_bank_en   (sccp_bank_en),
        .sccp_en        (sccp_en),
        .sound_out      (sound_out)
    );

    always #5 clk = ~clk;

    // One tick every third clock, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            ediv   = (ediv + 1) % 3;
            enable = run_en && (ediv == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] wexp(input logic [7:0] b);
`ifdef SCC_WAVE_READ_EN
        return b;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_snd(input string name, input int exp);
        check(name, int'($signed(sound_out)), exp);
    endtask

    task automatic tick_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_address    = a;
        bus_write_data = d;
        bus_write      = 1'b1;
        tick_clk();
        bus_write      = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input bit exp_hit);
        bus_address = a;
        bus_read    = 1'b1;
        if (exp_hit) exp_q.push_back(e);
        tick_clk();
        bus_read    = 1'b0;
    endtask

    task automatic rw(input logic [15:0] a, input logic [7:0] d, input logic [7:0] e);
        bus_address    = a;
        bus_write_data = d;
        bus_read       = 1'b1;
        bus_write      = 1'b1;
        exp_q.push_back(e);
        tick_clk();
        bus_read       = 1'b0;
        bus_write      = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < n * 3 + 30) begin
            @(posedge clk);
            guard++;
            if (enable) k++;
        end
        #1;
        if (k < n) check("tick_timeout", k, n);
    endtask

    // Monitor: every ready pulse is matched against the oldest expected read.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus_read_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected ready with data %h, no read expected", bus_read_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_read_data !== e) begin
                        errors++;
                        $display("FAIL rd_data actual %h expected %h", bus_read_data, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) tick_clk();
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            check("rst_ready", int'(bus_read_ready), 0);
            chk_snd("rst_sound", 0);
        end

        // SCC mode bus access
        bus_memory  = 1'b1;
        scc_bank_en = 1'b1;
        wr(16'h9800, 8'h7F);
        wr(16'h988F, 8'h00);
        rd(16'h9800, wexp(8'h7F), 1'b1);
        rd(16'h9880, 8'hFF, 1'b1);
        rd(16'h9F00, wexp(8'h7F), 1'b1);
        rd(16'h98A0, 8'hFF, 1'b1);
        wr(16'h9801, 8'h11);
        rw(16'h9801, 8'h22, wexp(8'h11));
        rd(16'h9801, wexp(8'h22), 1'b1);
        bus_memory = 1'b0;
        rd(16'h9800, 8'h00, 1'b0);
        bus_memory = 1'b1;

        // Ch0 constant full-scale tone
        for (int i = 0; i < 32; i++) wr(16'h9800 + 16'(i), 8'h7F);
        wr(16'h988A, 8'h0F);
        wr(16'h9880, 8'h10);
        wr(16'h9881, 8'h00);
        wr(16'h988F, 8'h01);
        run_en = 1'b1;
        wait_ticks(2);
        chk_snd("ch0_full", 119);
        wr(16'h988A, 8'h00);
        wait_ticks(2);
        chk_snd("ch0_vol0", 0);
        run_en = 1'b0;
        repeat (3) tick_clk();

        // Reset during a pending read suppresses the ready pulse
        bus_address = 16'h9800;
        bus_read    = 1'b1;
        n_reset     = 1'b0;
        tick_clk();
        bus_read    = 1'b0;
        check("rst_abort_ready", int'(bus_read_ready), 0);
        tick_clk();
        check("rst_abort_data", int'(bus_read_data), 0);
        chk_snd("rst_abort_sound", 0);
        n_reset = 1'b1;
        tick_clk();

        // Pointer walk with a single impulse at index 0
        wr(16'h9800, 8'h80);
        wr(16'h988A, 8'h0F);
        wr(16'h9880, 8'h14);
        wr(16'h9881, 8'h00);
        wr(16'h988F, 8'h01);
        run_en = 1'b1;
        wait_ticks(1);
        chk_snd("walk_t1", -120);
        wait_ticks(20);
        chk_snd("walk_t21", -120);
        wait_ticks(1);
        chk_snd("walk_t22", 0);
        wait_ticks(650);
        chk_snd("walk_t672", 0);
        wait_ticks(1);
        chk_snd("walk_t673_wrap", -120);

        // Period 8 freezes the pointer; period 9 releases it
        wr(16'h9880, 8'h08);
        wait_ticks(5);
        chk_snd("frozen_a", -120);
        wait_ticks(40);
        chk_snd("frozen_b", -120);
        wr(16'h9880, 8'h09);
        wait_ticks(15);
        chk_snd("unfrozen", 0);
        run_en = 1'b0;
        repeat (3) tick_clk();

        // SCC+ mode: ch4 owns a table; SCC mode replays ch3
        scc_bank_en  = 1'b0;
        sccp_bank_en = 1'b1;
        sccp_en      = 1'b1;
        wr(16'hB880, 8'h55);
        wr(16'hB860, 8'hC0);
        wr(16'hB8AE, 8'h0F);
        wr(16'hB8AF, 8'h10);
        rd(16'hB880, wexp(8'h55), 1'b1);
        rd(16'hB8A0, 8'hFF, 1'b1);
        rd(16'hB8C5, 8'hFF, 1'b1);
        run_en = 1'b1;
        wait_ticks(2);
        chk_snd("sccp_ch4_own", 79);
        sccp_en = 1'b0;
        wait_ticks(2);
        chk_snd("scc_ch4_ch3", -60);
        rd(16'hB880, 8'h00, 1'b0);
        rd(16'h9800, 8'h00, 1'b0);
        sccp_en = 1'b1;
        rd(16'hB880, wexp(8'h55), 1'b1);
        run_en = 1'b0;

        repeat (4) tick_clk();
        check("rd_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_scc.md
Name: ip_scc

Overview:
- Konami SCC / SCC+ wavetable sound generator for the MSX cartridge core.
- Five channels; each has a 32-sample signed 8-bit wavetable, 12-bit period, 4-bit volume and an enable bit. Outputs the mixed 11-bit signed sample.
- Bank/mapper decoding is external; this block only sees window-enable qualifiers plus the CPU bus.

Parameters:
- none

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- enable  in  1  sound tick strobe (1 clk wide, 1 in 3 clk); all tone counters advance only when high
- bus_address  in  16  CPU address
- bus_read_ready  out  1  1-clk pulse: bus_read_data valid
- bus_read_data  out  8  read data
- bus_write_data  in  8  write data
- bus_read  in  1  read strobe, 1 clk
- bus_write  in  1  write strobe, 1 clk
- bus_memory  in  1  1 = memory cycle; block ignores cycles with 0 (I/O)
- scc_bank_en  in  1  SCC register bank selected (window 9800h-9FFFh)
- sccp_bank_en  in  1  SCC+ register bank selected (window B800h-BFFFh)
- sccp_en  in  1  1 = SCC+ mode (independent ch4 wave), 0 = SCC compatible
- sound_out  out  11  mixed signed sample (two's complement)

Behaviour:
- Hit decode: bus_memory=1 and either:
  - sccp_en=0, scc_bank_en=1, A[15:11]=10011b; or
  - sccp_en=1, sccp_bank_en=1, A[15:11]=10111b.
- Offset = A[7:0], mirrored every 256 bytes.
- SCC mode offsets:
  - 00-7F: wave RAM ch0-ch3, 32 bytes each. Ch4 plays the ch3 table.
  - 80-89: period; even address = low 8 bits, odd address = high 4 bits (data[3:0]), ch0..ch4.
  - 8A-8E: volume ch0-4 (data[3:0]).
  - 8F: channel enable mask (data[4:0]).
  - 90-9F: mirror of 80-8F.
  - A0-FF: writes ignored.
- SCC+ mode offsets:
  - 00-9F: wave RAM ch0-ch4.
  - A0-A9: period.
  - AA-AE: volume.
  - AF: enable.
  - B0-BF: mirror of A0-AF.
  - C0-FF: writes ignored.
- Writes take effect on the clk edge sampling bus_write=1. A period write also reloads that channel's counter with the new value.
- Reads on a hit:
  - bus_read_ready pulses high exactly 1 clk after bus_read; bus_read_data is valid in the same cycle.
  - Wave offsets return the stored byte; all other offsets return FFh.
  - A miss produces no ready pulse and leaves bus_read_data unchanged.
- Tone generation per channel, on enable=1:
  - If the counter is 0: reload it with the period and increment the 5-bit wave pointer (wraps 31->0).
  - Otherwise: decrement the counter.
  - If period <= 8, the channel is frozen: pointer holds, counter not updated.
- Channel output = (signed wave byte x volume) >>> 4 (arithmetic shift); forced to 0 when the enable bit is clear.
- Mixing: sound_out = sign-extended sum of the 5 channel outputs, registered, updated on enable.
- Range: -600..+595; no clipping needed.
- Simultaneous read and write at the same clk: the write is performed and the read returns the pre-write byte.
- Reset (asynchronous):
  - All wave RAM, periods, volumes, enable mask, counters and pointers = 0.
  - sound_out = 0, bus_read_ready = 0, bus_read_data = 00h.
- Reset mid-operation aborts any pending read ready pulse.
- sccp_en may change at any time; it takes effect immediately for both decode and ch4 wave source.

Optional Feature:
- Macro SCC_WAVE_READ_EN.
- Defined: wave RAM reads behave as specified above.
- Not defined: wave reads return FFh. The ready pulse is still generated for hits.

Test Plan:
- Hold n_reset=0, release, run 10 clk with no bus activity -> sound_out=0, bus_read_ready=0 throughout.
- SCC mode (scc_bank_en=1):
  - Write 7Fh to 9800h, 00h to 988Fh, read 9800h -> bus_read_ready 1 clk later, data 7Fh.
  - Read 9880h -> FFh.
- Ch0: wave all 7Fh, volume 0Fh, enable 01h, period 0010h -> sound_out = 119 within 1 enable tick; with volume 0 -> 0.
- Ch0 wave: byte0 = 80h, others 00h, period 20 -> after (period+1)x32 enable ticks the pointer wraps; sound_out = -120 at pointer 0, 0 otherwise.
- Period 8 with ch enabled -> sound_out constant; after writing period 9, sound_out changes over subsequent enable ticks.
- SCC+ (sccp_en=1, sccp_bank_en=1): write B880h = 55h; set sccp_en=0 -> ch4 plays the ch3 table (B860h region); read B880h -> 55h in SCC+ mode.
